int_dist: RTL
=============

# int_dist

Interrupt distributor between the protocol controller's `int_sig` bus and the two RISC-V cores in the multi-core power-measurement build.
- Edge-detects each controller interrupt and latches it as pending.
- Routes each source to one of the two cores, under a per-core enable mask.
- Presents each core with a single registered request/ID and runs a claim / end-of-interrupt handshake per core.

## Interface
Parameters:
- `INT_W`, default `` `INT_SIG_WIDTH ``: number of interrupt sources; legal range 1..8.
- `IDW`, default 3: width of the interrupt ID; must satisfy 2^IDW >= INT_W.

Ports:
- `clk` in 1: system clock (`CLK_BUF` domain); single clock.
- `rst` in 1: reset, synchronous and active-high.
- `int_sig` in INT_W: interrupt lines from the protocol controller.
- `cfg_we` in 1: configuration write strobe.
- `cfg_wdata` in 32: configuration word.
  - [7:0] route: bit i = 0 sends source i to core 0, 1 sends it to core 1.
  - [15:8] en0: core 0 enable mask.
  - [23:16] en1: core 1 enable mask.
  - Bits at or above INT_W within each field are ignored.
- `cfg_rdata` out 32: registered readback in the same layout; all unused bits read 0.
- `irq0`, `irq1` out 1: interrupt request to core 0 / core 1.
- `irq_id0`, `irq_id1` out IDW: source index for core 0 / core 1.
- `ack0`, `ack1` in 1: one-cycle claim pulse from core 0 / core 1.
- `eoi0`, `eoi1` in 1: one-cycle end-of-interrupt pulse from core 0 / core 1.
- `pend` out INT_W: pending register, for debug.

## Operation
- Edge detect:
  - `int_q` holds `int_sig` from the previous cycle; `edge = int_sig & ~int_q`.
  - `int_q` resets to 0, so a line that is high when reset releases counts as an edge.
- Pending:
  - `pend[i]` sets on `edge[i]`.
  - `pend[i]` clears when the core that owns source i claims it.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Masked sources still latch as pending; they are simply not presented to a core.
- Eligible set for core c: `pend & en_c & (route == c)`. The winner is the lowest-index eligible bit.
- Per-core FSM, identical for both cores:
  - IDLE: if the eligible set is nonempty, latch the winner into `irq_id_c`, assert `irq_c`, go to REQ.
  - REQ:
    - `irq_id_c` tracks the current lowest eligible bit every cycle.
    - If the eligible set empties (mask change or reroute), drop `irq_c` and go to IDLE.
    - On `ack_c`: clear `pend[irq_id_c]`, drop `irq_c`, hold `irq_id_c`, go to SERVICE.
  - SERVICE: `irq_c` stays low and `irq_id_c` is held. On `eoi_c`, go to IDLE.
- Ignored inputs: `ack_c` outside REQ and `eoi_c` outside SERVICE have no effect. `ack_c` and `eoi_c` asserted in the same cycle: only the one valid for the current state acts.
- Configuration writes:
  - A `cfg_we` write takes effect at the clock edge and overwrites route and both masks atomically.
  - A core already in SERVICE is unaffected by the write.
- Reset (also when asserted mid-operation):
  - route, en0 and en1 = 0, so everything is masked.
  - `pend` = 0, `int_q` = 0.
  - Both FSMs go to IDLE.
  - `irq0` = `irq1` = 0, `irq_id0` = `irq_id1` = 0, `cfg_rdata` = 0.

## Timing
- `int_sig[i]` first sampled high at edge k → `pend[i]` = 1 after edge k → `irq_c` = 1 after edge k+1. Latency is 2 cycles.
- `ack_c` sampled at edge m → `irq_c` = 0 and `pend` bit cleared after edge m.
- `eoi_c` at edge n → FSM back in IDLE after edge n. If another source is eligible, `irq_c` = 1 after edge n+1.
- `cfg_rdata` reflects a write one cycle after `cfg_we`. A newly enabled pending source raises `irq_c` one cycle after the write.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `INT_DIST_SYNC_EN`:
  - Defined: `int_sig` passes through a two-flop synchronizer ahead of the edge detector. Input-to-`irq` latency becomes 4 cycles. The synchronizer flops reset to 0.
  - Undefined: `int_sig` is used directly and latency is 2 cycles.

## Test plan
- Route/enable and latency: after reset, write `cfg_wdata` = 0x00_00_01_00 (route = 0, en0 = 0x01). Pulse `int_sig[0]` → `pend` = 0x1 after 1 cycle; `irq0` = 1 with `irq_id0` = 0 after 2 cycles; `irq1` stays 0.
- Priority and service lockout: enable all sources on core 0 and raise sources 2 and 1 together.
  - `irq_id0` = 1; `ack0` clears `pend[1]`; `irq0` drops.
  - `irq0` stays low through SERVICE; `eoi0` → `irq0` = 1 with `irq_id0` = 2 two cycles later.
- Dual core: route = 0x02, en0 = en1 = 0x03, pulse sources 0 and 1 → `irq0`/`irq_id0` = 0 and `irq1`/`irq_id1` = 1 in the same cycle. Claims on each core are independent.
- Set/clear collision: new edge on source 0 in the same cycle as `ack0` for source 0 → `pend[0]` remains 1 and `irq0` reasserts after `eoi0`.
- Masking in REQ and reset mid-operation:
  - Clear en0 while `irq0` = 1 → `irq0` = 0 next cycle and `pend` is retained.
  - Assert `rst` while core 0 is in SERVICE → all outputs 0, `cfg_rdata` = 0; a stray `eoi0` afterwards has no effect.
- Build with `INT_DIST_SYNC_EN` defined → the first scenario shows `irq0` after 4 cycles.

Source files
------------

// File: rtl/int_dist.sv
`default_nettype none
// ============================================================================
//  Module   : int_dist
//  Brief    : Interrupt distributor. Edge-detects controller interrupt lines,
//             latches them as pending, routes each source to one of two cores
//             under per-core enable masks and runs a claim / end-of-interrupt
//             handshake per core.
//  Option   : INT_DIST_SYNC_EN - adds a two-flop synchronizer on int_sig
//             (input-to-irq latency 4 cycles instead of 2).
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef INT_SIG_WIDTH
`define INT_SIG_WIDTH 8
`endif

module int_dist #(
    parameter int INT_W = `INT_SIG_WIDTH,
    parameter int IDW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] int_sig,
    input  logic             cfg_we,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             irq0,
    output logic             irq1,
    output logic [IDW-1:0]   irq_id0,
    output logic [IDW-1:0]   irq_id1,
    input  logic             ack0,
    input  logic             ack1,
    input  logic             eoi0,
    input  logic             eoi1,
    output logic [INT_W-1:0] pend
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Lowest-index set bit of v (0 when v is empty; callers qualify with |v).
    function automatic logic [IDW-1:0] f_lowest(input logic [INT_W-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = INT_W - 1; i >= 0; i--) begin
            if (v[i]) idx = IDW'(i);
        end
        return idx;
    endfunction

    logic [INT_W-1:0] w_int_in;
    logic [INT_W-1:0] r_int_q;
    logic [INT_W-1:0] w_edge;
    logic [INT_W-1:0] r_pend;
    logic [INT_W-1:0] r_route;
    logic [INT_W-1:0] r_en0;
    logic [INT_W-1:0] r_en1;
    logic [31:0]      w_cfg;
    logic [1:0]       w_ack;
    logic [1:0]       w_eoi;
    logic [INT_W-1:0] w_elig  [2];
    logic [INT_W-1:0] w_clr_v [2];
    logic             w_irq_v [2];
    logic [IDW-1:0]   w_id_v  [2];
    logic             w_cfg_unused;

    // Word bits outside the three fields are deliberately discarded.
    assign w_cfg_unused = ^cfg_wdata;

`ifdef INT_DIST_SYNC_EN
    logic [INT_W-1:0] r_sync1;
    logic [INT_W-1:0] r_sync2;

    // Two-flop synchronizer ahead of the edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= int_sig;
            r_sync2 <= r_sync1;
        end
    end

    assign w_int_in = r_sync2;
`else
    assign w_int_in = int_sig;
`endif

    // Previous-cycle copy of the interrupt lines; zero after reset so a line
    // already high at reset release is seen as an edge.
    always_ff @(posedge clk) begin
        if (rst) r_int_q <= '0;
        else     r_int_q <= w_int_in;
    end

    assign w_edge = w_int_in & ~r_int_q;

    // Pending latch: claims clear, new edges set, and set wins a collision.
    always_ff @(posedge clk) begin
        if (rst) r_pend <= '0;
        else     r_pend <= (r_pend & ~(w_clr_v[0] | w_clr_v[1])) | w_edge;
    end

    // Route and enable masks, overwritten together on a configuration write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_route <= '0;
            r_en0   <= '0;
            r_en1   <= '0;
        end else if (cfg_we) begin
            r_route <= cfg_wdata[INT_W-1:0];
            r_en0   <= cfg_wdata[8 +: INT_W];
            r_en1   <= cfg_wdata[16 +: INT_W];
        end
    end

    // Readback image of the configuration flops; unused bits read 0.
    always_comb begin
        w_cfg               = '0;
        w_cfg[INT_W-1:0]    = r_route;
        w_cfg[8 +: INT_W]   = r_en0;
        w_cfg[16 +: INT_W]  = r_en1;
    end

    assign w_elig[0] = r_pend & r_en0 & ~r_route;
    assign w_elig[1] = r_pend & r_en1 &  r_route;
    assign w_ack     = {ack1, ack0};
    assign w_eoi     = {eoi1, eoi0};

    for (genvar c = 0; c < 2; c++) begin : g_core
        state_t           r_state;
        state_t           w_state_nxt;
        logic             r_irq;
        logic             w_irq_nxt;
        logic [IDW-1:0]   r_id;
        logic [IDW-1:0]   w_id_nxt;
        logic [INT_W-1:0] w_clr;
        logic             w_any;
        logic [IDW-1:0]   w_win;

        assign w_any = |w_elig[c];
        assign w_win = f_lowest(w_elig[c]);

        // Request state, request line and presented ID for this core.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_IDLE;
                r_irq   <= 1'b0;
                r_id    <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_irq   <= w_irq_nxt;
                r_id    <= w_id_nxt;
            end
        end

        // Next state: present the lowest eligible source, follow it while
        // requesting, retire it on claim and wait for end-of-interrupt.
        // A claim wins over a same-cycle loss of eligibility, since the core
        // is acknowledging the ID that was already on its outputs.
        always_comb begin
            w_state_nxt = r_state;
            w_irq_nxt   = r_irq;
            w_id_nxt    = r_id;
            w_clr       = '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        w_id_nxt    = w_win;
                        w_irq_nxt   = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack[c]) begin
                        for (int i = 0; i < INT_W; i++) begin
                            w_clr[i] = (r_id == IDW'(i));
                        end
                        w_irq_nxt   = 1'b0;
                        w_state_nxt = ST_SERVICE;
                    end else if (!w_any) begin
                        w_irq_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_id_nxt    = w_win;
                    end
                end
                ST_SERVICE: begin
                    w_irq_nxt = 1'b0;
                    if (w_eoi[c]) w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_irq_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        assign w_clr_v[c] = w_clr;
        assign w_irq_v[c] = r_irq;
        assign w_id_v[c]  = r_id;
    end

    assign cfg_rdata = w_cfg;
    assign pend      = r_pend;
    assign irq0      = w_irq_v[0];
    assign irq1      = w_irq_v[1];
    assign irq_id0   = w_id_v[0];
    assign irq_id1   = w_id_v[1];

endmodule

`default_nettype wire
